// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - sequential FIR multiply-accumulate with round and saturate
// One shared multiplier walks the latched delay line; result is rounded, clipped and strobed.
module fir_mac_seq #(
   parameter int NUM_TAPS = 3,
   parameter int DATA_W   = 3,
   parameter int COEFF_W  = 16,
   parameter int ACC_W    = 21,
   parameter int SHIFT    = 0,
   parameter int OUT_W    = 16,
   localparam int IDX_W   = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1
) (
   input  logic                         iClk_12M,
   input  logic                         iRsn,
   input  logic                         iStart,
   input  logic [NUM_TAPS*DATA_W-1:0]   iDelay,
   input  logic signed [COEFF_W-1:0]    iCoeff,
   output logic [IDX_W-1:0]             oCoeffAddr,
   output logic                         oBusy,
   output logic                         oValid,
   output logic signed [OUT_W-1:0]      oFirOut,
   output logic                         oSat
);

   localparam int PROD_W = DATA_W + COEFF_W;
   localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
   localparam logic signed [ACC_W:0] RND =
      (SHIFT > 0) ? ((ACC_W+1)'(1) <<< RND_SH) : '0;
   localparam logic signed [ACC_W:0] MAX_V =
      {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [ACC_W:0] MIN_V =
      {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                         state;
   logic [IDX_W-1:0]               idx;
   logic [NUM_TAPS*DATA_W-1:0]     delay_q;
   logic signed [ACC_W-1:0]        acc;
   logic signed [DATA_W-1:0]       tap;
   logic signed [PROD_W-1:0]       prod;
   logic signed [ACC_W:0]          acc_rnd;
   logic signed [ACC_W:0]          r_sh;
   logic signed [ACC_W:0]          r_sat;
   logic                           clip;

   assign tap  = delay_q[idx*DATA_W +: DATA_W];
   assign prod = PROD_W'(tap) * PROD_W'(iCoeff);

   // One extra bit of headroom so the rounding add cannot wrap.
   assign acc_rnd = (ACC_W+1)'(acc) + RND;
   assign r_sh    = acc_rnd >>> SHIFT;

   always_comb begin
      r_sat = r_sh;
      clip  = 1'b0;
      if (r_sh > MAX_V) begin
         r_sat = MAX_V;
         clip  = 1'b1;
      end else if (r_sh < MIN_V) begin
         r_sat = MIN_V;
         clip  = 1'b1;
      end
   end

   assign oCoeffAddr = (state == S_MAC) ? idx : '0;
   assign oBusy      = (state != S_IDLE);

   always_ff @(posedge iClk_12M) begin
      if (!iRsn) begin
         state   <= S_IDLE;
         idx     <= '0;
         acc     <= '0;
         delay_q <= '0;
         oFirOut <= '0;
         oSat    <= 1'b0;
         oValid  <= 1'b0;
      end else begin
         oValid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (iStart) begin
                  delay_q <= iDelay;
                  acc     <= '0;
                  idx     <= '0;
                  state   <= S_MAC;
               end
            end
            S_MAC: begin
               acc <= acc + ACC_W'(prod);
               if (idx == LAST_IDX) state <= S_OUT;
               else                 idx   <= idx + 1'b1;
            end
            S_OUT: begin
               oFirOut <= r_sat[OUT_W-1:0];
               oSat    <= clip;
               oValid  <= 1'b1;
               idx     <= '0;
               state   <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Parametrised sequential multiply-accumulate engine for the FIR datapath: one shared multiplier steps through NUM_TAPS delay-line samples against coefficients fetched by tap index. The accumulator is cleared per output sample, and the result is rounded, saturated and presented with a one-cycle valid strobe. It replaces the fixed 3-tap, 16-bit, externally sequenced accumulator with an internal sequencer, a start/busy/valid handshake, configurable widths, and rounding and saturation.

## Interface
- NUM_TAPS, 3: number of taps accumulated per output sample (≥1)
- DATA_W, 3: signed sample width per tap
- COEFF_W, 16: signed coefficient width
- ACC_W, 21: signed accumulator width; must be ≥ DATA_W+COEFF_W+clog2(NUM_TAPS)
- SHIFT, 0: right-shift applied to the accumulator before saturation (0..ACC_W-1)
- OUT_W, 16: signed output width
- iClk_12M  in  1  sole clock, rising edge
- iRsn  in  1  reset, synchronous, active-low (one clock; reset is synchronous and active-low)
- iStart  in  1  request one output sample; honoured only in IDLE
- iDelay  in  NUM_TAPS*DATA_W  signed tap samples, tap k at bits [k*DATA_W +: DATA_W]; sampled only on the accepting edge
- iCoeff  in  COEFF_W  signed coefficient for tap oCoeffAddr, valid in the same cycle (combinational ROM)
- oCoeffAddr  out  clog2(NUM_TAPS) (min 1)  current tap index
- oBusy  out  1  high in MAC and OUT states
- oValid  out  1  one-cycle strobe: oFirOut/oSat updated
- oFirOut  out  OUT_W  signed result, held until the next oValid
- oSat  out  1  the result was clipped; qualified by oValid, held with oFirOut

## Operation
- FSM states: IDLE, MAC, OUT.
- IDLE: if iStart=1 on an edge, the block latches iDelay into an internal register, clears the accumulator, sets the tap index to 0 and goes to MAC. Otherwise it stays in IDLE.
- MAC: oCoeffAddr = index. Each edge does acc <= acc + sext(delay[index]) * iCoeff, a full-precision signed product of DATA_W+COEFF_W bits sign-extended to ACC_W.
  - If index = NUM_TAPS-1, go to OUT; otherwise index++.
- OUT: compute r = (acc + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >>> SHIFT, an arithmetic shift that rounds half toward +inf.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1]. oSat = 1 if clipping occurred.
  - Register oFirOut and oSat, pulse oValid, return to IDLE.
- iStart while oBusy=1 is ignored. No queueing, no error flag.
- iDelay changes after the accepting edge have no effect on the sample in flight.
- oCoeffAddr = 0 in IDLE and OUT.
- Reset (iRsn=0 on an edge), including mid-operation: state IDLE, index 0, accumulator 0, oFirOut 0, oSat 0, oValid 0, oBusy 0. The sample in flight is discarded and no oValid follows.
- Accumulator overflow cannot occur when the ACC_W rule holds; the block does not check for it.

## Timing
- Edge T accepts iStart. oBusy is high from T+1 until oValid. MAC occupies cycles T+1..T+NUM_TAPS.
- The OUT cycle is T+NUM_TAPS+1. oValid is high during cycle T+NUM_TAPS+2 (after that edge), with the new oFirOut/oSat.
- Latency: start edge to valid = NUM_TAPS+2 edges. oBusy=0 in the oValid cycle.
- A new iStart may be accepted on the edge ending the oValid cycle. Back-to-back period = NUM_TAPS+2 cycles.
- iCoeff must settle within the cycle in which oCoeffAddr is presented. There is no extra ROM latency.
- All outputs are registered except oCoeffAddr and oBusy, which decode registered state/index.

## Test plan
- Defaults, iDelay taps {1,-2,3}, ROM {100,200,300}, iStart pulse -> oCoeffAddr 0,1,2 in consecutive cycles; oValid exactly 5 edges after the start edge with oFirOut=600, oSat=0.
- Defaults, taps {3,3,3}, coeffs all 32767 -> oFirOut=32767, oSat=1. Taps {-4,-4,-4}, coeffs all 32767 -> oFirOut=-32768, oSat=1.
- SHIFT=4, acc 600 (taps {1,-2,3}) -> oFirOut=38. Negated taps {-1,2,-3} -> oFirOut=-37. oSat=0 in both.
- iStart held high continuously -> results every 5 cycles; iStart pulses mid-MAC ignored; iDelay toggled mid-MAC does not change the result.
- iRsn=0 for one edge during MAC -> no oValid; all outputs 0. Next iStart yields the correct fresh result, with no residue from the aborted accumulation.
- NUM_TAPS=8, DATA_W=12, ACC_W=31, SHIFT=15: random signed vectors against a reference model -> bit-exact oFirOut/oSat, latency 10 edges.
